// File: rtl/rbm_visible_layer.sv
// rtl/rbm_visible_layer.sv - RBM hidden-to-visible reconstruction, one MAC lane, PLAN sigmoid, optional LFSR sampling
// Optional feature macro: RBM_VISIBLE_SAMPLE_EN (builds the LFSR and drives VisibleS).
module rbm_visible_layer #(
    parameter int          input_bitlength = 12,
    parameter int          frac_bits       = 8,
    parameter int          sg_bitlength    = 8,
    parameter int          in_dim          = 15,
    parameter int          out_dim         = 5,
    parameter logic [15:0] lfsr_seed       = 16'hACE1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [out_dim-1:0]                          HiddenS,
    input  logic [in_dim*out_dim*input_bitlength-1:0]   V_WeightI,
    input  logic [in_dim*input_bitlength-1:0]           V_BiasI,
    output logic                                        busy,
    output logic                                        done,
    output logic [in_dim*sg_bitlength-1:0]              VisibleP,
    output logic [in_dim-1:0]                           VisibleS
);

    localparam int AW = input_bitlength + $clog2(out_dim + 1);
    localparam int IW = (in_dim > 1) ? $clog2(in_dim) : 1;
    localparam int JW = (out_dim > 1) ? $clog2(out_dim) : 1;
    localparam int CW = sg_bitlength + 1;
    localparam int XW = AW - input_bitlength;

    localparam logic [IW-1:0] I_LAST = IW'(in_dim - 1);
    localparam logic [JW-1:0] J_LAST = JW'(out_dim - 1);

    // PLAN breakpoints in accumulator Q format: 5.0, 2.375, 1.0
    localparam logic [AW:0] T_SAT = (AW+1)'(5 << frac_bits);
    localparam logic [AW:0] T_MID = (AW+1)'((19 << frac_bits) >> 3);
    localparam logic [AW:0] T_ONE = (AW+1)'(1 << frac_bits);
    localparam logic [AW:0] ONE_A = (AW+1)'(1);

    localparam logic [CW-1:0] FULL = CW'(1 << sg_bitlength);
    localparam logic [CW-1:0] K32  = CW'((27 << sg_bitlength) >> 5);
    localparam logic [CW-1:0] K8   = CW'((5 << sg_bitlength) >> 3);
    localparam logic [CW-1:0] K4   = CW'(1 << (sg_bitlength - 1));

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_SIG, S_DONE} state_t;

    state_t                        state;
    logic [IW-1:0]                 idx_i;
    logic [JW-1:0]                 idx_j;
    logic signed [AW-1:0]          acc;
    logic [out_dim-1:0]            h_reg;

    logic [input_bitlength-1:0]    w_cur;
    logic [input_bitlength-1:0]    b_first;
    logic [input_bitlength-1:0]    b_next;
    logic signed [AW-1:0]          w_ext;
    logic [AW:0]                   mag;
    logic [AW+sg_bitlength:0]      mag_sh;
    logic [CW-1:0]                 code;
    logic [CW-1:0]                 neg_code;
    logic [sg_bitlength-1:0]       p_val;
    int                            w_base;
    int                            b_base;
    int                            p_base;

    always_comb begin
        w_base  = (int'(idx_i) * out_dim + int'(idx_j)) * input_bitlength;
        b_base  = (idx_i == I_LAST) ? 0 : (int'(idx_i) + 1) * input_bitlength;
        p_base  = int'(idx_i) * sg_bitlength;
        w_cur   = V_WeightI[w_base +: input_bitlength];
        b_next  = V_BiasI[b_base +: input_bitlength];
        b_first = V_BiasI[input_bitlength-1:0];
        w_ext   = h_reg[idx_j] ? {{XW{w_cur[input_bitlength-1]}}, w_cur} : '0;
    end

    // Sigmoid on |acc|; slopes are exact right shifts of the magnitude scaled to the output code
    always_comb begin
        mag    = acc[AW-1] ? (~{acc[AW-1], acc} + ONE_A) : {acc[AW-1], acc};
        mag_sh = {mag, {sg_bitlength{1'b0}}};
        if (mag >= T_SAT)
            code = FULL;
        else if (mag >= T_MID)
            code = CW'(mag_sh >> (frac_bits + 5)) + K32;
        else if (mag >= T_ONE)
            code = CW'(mag_sh >> (frac_bits + 3)) + K8;
        else
            code = CW'(mag_sh >> (frac_bits + 2)) + K4;
        neg_code = FULL - code;
        if (acc[AW-1])
            p_val = neg_code[sg_bitlength-1:0];
        else
            p_val = code[sg_bitlength] ? '1 : code[sg_bitlength-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            VisibleP <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            acc      <= '0;
            h_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        h_reg <= HiddenS;
                        acc   <= {{XW{b_first[input_bitlength-1]}}, b_first};
                        idx_i <= '0;
                        idx_j <= '0;
                        busy  <= 1'b1;
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc <= acc + w_ext;
                    if (idx_j == J_LAST)
                        state <= S_SIG;
                    else
                        idx_j <= idx_j + 1'b1;
                end
                S_SIG: begin
                    VisibleP[p_base +: sg_bitlength] <= p_val;
                    if (idx_i == I_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx_i <= idx_i + 1'b1;
                        idx_j <= '0;
                        acc   <= {{XW{b_next[input_bitlength-1]}}, b_next};
                        state <= S_ACC;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RBM_VISIBLE_SAMPLE_EN
    logic [15:0] lfsr;

    // Compare uses the LFSR value before this SIG cycle's step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr     <= lfsr_seed;
            VisibleS <= '0;
        end else if (state == S_SIG) begin
            VisibleS[idx_i] <= (lfsr[sg_bitlength-1:0] < p_val);
            lfsr            <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^lfsr_seed;
    assign VisibleS    = '0;
`endif

endmodule

// File: doc/rbm_visible_layer.md
# rbm_visible_layer

Reconstruction (hidden→visible) half of the RBM Gibbs step: the reverse direction of the forward RBM layer. It takes the binary hidden sample vector and the same visible×hidden weight matrix, and adds the visible biases. Each visible unit gets a sigmoid probability and, optionally, a stochastic binary sample. It is time-multiplexed with one MAC lane, one hidden term per cycle, under a start/busy/done handshake. It sits after the forward layer in the contrastive-divergence loop.

## Interface
- input_bitlength, 12: width of each signed weight/bias word, two's complement.
- frac_bits, 8: fractional bits of weights, biases and accumulator (Q format).
- sg_bitlength, 8: width of the unsigned probability output, all fractional bits.
- in_dim, 15: number of visible units (outputs).
- out_dim, 5: number of hidden units (inputs).
- lfsr_seed, 16'hACE1: nonzero reset value of the sampling LFSR.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- HiddenS  in  out_dim  hidden sample bits, bit j = h_j.
- V_WeightI  in  in_dim*out_dim*input_bitlength  packed W[i][j], same packing as the forward layer's weight port (visible i, hidden j).
- V_BiasI  in  in_dim*input_bitlength  packed visible biases b_i.
- busy  out  1  high while a reconstruction is in progress.
- done  out  1  one-cycle completion pulse.
- VisibleP  out  in_dim*sg_bitlength  packed probabilities P_i.
- VisibleS  out  in_dim  sampled visible bits.

## Operation
- Reset (reset=0): state IDLE; busy=0, done=0, VisibleP=0, VisibleS=0; LFSR=lfsr_seed; indices i, j and accumulator cleared.
- IDLE: start=1 latches HiddenS into an internal register. It then loads acc=sign-extended b_0, sets i=0, j=0 and goes to ACC. V_WeightI and V_BiasI must be held stable until done.
- ACC: acc += h_j ? W[i][j] : 0, one hidden term per cycle. j increments; after j=out_dim-1 the state goes to SIG.
- SIG: writes P_i (and S_i) for the current i and steps the LFSR once.
  - If i=in_dim-1, go to DONE.
  - Otherwise i++, j=0, acc=b_{i+1}, go to ACC.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored. start held high in IDLE after DONE begins a new run.
- Accumulator width is input_bitlength+$clog2(out_dim+1), signed; it never overflows, so no saturation is needed.
- Sigmoid uses the PLAN approximation on a=|acc| (real value acc/2^frac_bits):
  - a≥5: y=1
  - 2.375≤a<5: y=a/32+0.84375
  - 1≤a<2.375: y=a/8+0.625
  - a<1: y=a/4+0.5
- Output code: c=floor(y·2^sg_bitlength), computed exactly with shifts, in the range [2^(sg-1), 2^sg].
  - acc≥0: P_i=min(c, 2^sg−1).
  - acc<0: P_i=2^sg−c.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. S_i = (LFSR[sg_bitlength-1:0] < P_i), using the LFSR value before that SIG cycle's step.
- VisibleP and VisibleS entries hold their value until rewritten by the next run; no clear at start.
- Reset mid-run aborts immediately to the reset state, with no done pulse.

## Timing
- Start accepted at rising edge E0; busy goes high after E0.
- Each visible unit takes out_dim ACC cycles plus 1 SIG cycle.
- P_i is valid after edge E0+(i+1)(out_dim+1).
- done is high during the cycle following edge E0+in_dim(out_dim+1), which is cycle 91 for the defaults. busy is low in that same cycle.
- Minimum start-to-start interval: in_dim(out_dim+1)+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- RBM_VISIBLE_SAMPLE_EN defined: the LFSR and comparators are built, and VisibleS is driven as described.
- RBM_VISIBLE_SAMPLE_EN undefined: no LFSR; VisibleS is tied to 0. VisibleP and all timing are unchanged.

## Test plan
All cases use default parameters.
- Reset with reset=0 mid-ACC → busy=0, done=0, VisibleP=0, VisibleS=0 immediately; a new start afterwards runs a full 91-cycle pass.
- HiddenS=0, all b_i=0 → every P_i=128; done after 91 cycles; busy high for 90 cycles.
- HiddenS=5'b00001, W[i][0]=0x100 (+1.0), biases 0 → P_i=192. Repeat with W[i][0]=0xF00 (−1.0) → P_i=64.
- HiddenS=5'b00011, W[i][0]=W[i][1]=0x100, b_i=0 → acc=2.0, P_i=224. With HiddenS=5'b00010 (weights unchanged) → acc=1.0, P_i=192 (masking check).
- b_i=0x500 (+5.0), HiddenS=0 → P_i=255 and VisibleS=1 except where LFSR low byte=255. b_i=0xB00 (−5.0) → P_i=0, VisibleS=0. Pulse start during busy → no effect on done timing.
- With the macro undefined → VisibleS stays 0 in every case above; VisibleP values are identical.
